// File: rtl/usb_tx.sv
`default_nettype none
// ============================================================================
// usb_tx : full-speed USB transmit serializer (SYNC, NRZI, bit stuffing, EOP)
// Revision: 1.0
// ============================================================================
module usb_tx (
  input  logic       clk48,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       usb_dp_out,
  output logic       usb_dn_out,
  output logic       usb_oe,
  output logic       busy,
  output logic       tx_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SYNC = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_EOP  = 2'd3;

  logic [1:0] state, state_nxt;
  logic [1:0] phase;
  logic [2:0] bit_idx;
  logic [2:0] ones;
  logic [7:0] shifter, hold_data;
  logic       shift_last, hold_last, hold_full;
  logic       line_j;
  logic       err_q;

  logic boundary, stuff_now, byte_end, to_eop, underflow;
  logic load_now, send_bit, data_bit, accept, se0;

  // bit_idx: SYNC = bit on the line, DATA = next shifter bit (0 = byte done),
  // EOP = symbol index (0,1 = SE0, 2 = J)
  always_comb begin
    boundary  = (phase == 2'd3);
    stuff_now = (state == S_DATA) && (ones == 3'd6);
    byte_end  = (state == S_DATA) && (bit_idx == 3'd0) && !stuff_now;
    to_eop    = boundary && byte_end && (shift_last || !hold_full);
    underflow = boundary && byte_end && !shift_last && !hold_full;
    load_now  = boundary && (((state == S_SYNC) && (bit_idx == 3'd7)) ||
                             (byte_end && !shift_last && hold_full));
    send_bit  = boundary && ((state == S_SYNC) ||
                             ((state == S_DATA) && !stuff_now && !to_eop));
    if (load_now)
      data_bit = hold_data[0];
    else if (state == S_SYNC)
      data_bit = (bit_idx == 3'd6);
    else
      data_bit = shifter[bit_idx];
    tx_ready  = (!hold_full || load_now) && (state != S_EOP);
    accept    = tx_valid && tx_ready;
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (hold_full) state_nxt = S_SYNC;
      S_SYNC:  if (load_now) state_nxt = S_DATA;
      S_DATA:  if (to_eop) state_nxt = S_EOP;
      S_EOP:   if (boundary && (bit_idx == 3'd2)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    se0        = (state == S_EOP) && (bit_idx != 3'd2);
    busy       = (state != S_IDLE);
    usb_oe     = busy;
    usb_dp_out = !se0 && line_j;
    usb_dn_out = !se0 && !line_j;
    tx_err     = err_q;
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= 2'd0;
      bit_idx    <= 3'd0;
      ones       <= 3'd0;
      shifter    <= 8'd0;
      shift_last <= 1'b0;
      hold_data  <= 8'd0;
      hold_last  <= 1'b0;
      hold_full  <= 1'b0;
      line_j     <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      err_q <= underflow;

      if (accept) begin
        hold_data <= tx_data;
        hold_last <= tx_last;
        hold_full <= 1'b1;
      end else if (load_now) begin
        hold_full <= 1'b0;
      end

      if (load_now) begin
        shifter    <= hold_data;
        shift_last <= hold_last;
      end

      if (state == S_IDLE) begin
        phase <= 2'd0;
        // first SYNC bit is a 0, so the line leaves J for K
        if (hold_full) begin
          line_j  <= 1'b0;
          ones    <= 3'd0;
          bit_idx <= 3'd0;
        end
      end else begin
        phase <= phase + 2'd1;
        if (send_bit) begin
          if (!data_bit)
            line_j <= !line_j;
          ones    <= data_bit ? ones + 3'd1 : 3'd0;
          bit_idx <= load_now ? 3'd1 : bit_idx + 3'd1;
        end else if (boundary && stuff_now) begin
          line_j <= !line_j;
          ones   <= 3'd0;
        end else if (to_eop) begin
          line_j  <= 1'b1;
          bit_idx <= 3'd0;
          ones    <= 3'd0;
        end else if (boundary && (state == S_EOP)) begin
          if (bit_idx == 3'd2) begin
            bit_idx    <= 3'd0;
            shift_last <= 1'b0;
          end else begin
            bit_idx <= bit_idx + 3'd1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
